hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
Memory-mapped controller that time-multiplexes an 8-digit common-anode 7-segment display from a 32-bit value written by the core. Each scan slot it presents one 4-bit nibble to the downstream nibble-to-segment decoder and drives the matching active-low anode line. Provides a per-digit enable mask, leading-zero suppression and anti-ghosting guard blanking. Sits between the core's peripheral bus and the segment decoder feeding the board display.

Parameters:
DIGITS, 8, number of digits scanned; fixed at 8 to match the 32-bit data register.
CLK_DIV, 1000, clock cycles per digit slot; must be greater than GUARD+1.
GUARD, 16, cycles at the start of each slot with all anodes off; must be at least 1.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
req_i  input  1  bus access strobe, one cycle
we_i  input  1  1 = write, 0 = read; qualified by req_i
addr_i  input  4  byte address: 0x0 DATA, 0x4 MASK, 0x8 CTRL
wdata_i  input  32  write data
rdata_o  output  32  read data, valid the cycle after a read req_i
nibble_o  output  4  nibble for the current digit, to the segment decoder
an_o  output  8  anode selects, active-low, one-hot-low when lit
dp_o  output  1  decimal point, active-low

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: DATA=0, MASK=0xFF, CTRL=0x1 (enable=1, lzs=0, dp mask=0), an_o=0xFF, nibble_o=0, dp_o=1, rdata_o=0, digit index=0, slot counter=0, state=GUARD.
- Registers:
  - DATA[31:0]: digit i shows DATA[4i+3:4i].
  - MASK[7:0]: bit i=1 enables digit i.
  - CTRL: bit0 enable; bit1 leading-zero suppress (lzs); bits[15:8] dp mask, bit 8+i lights the dp on digit i.
- Writes: a write with req_i&we_i updates the register at the next clk_i edge. Writes to unmapped addresses are ignored. Unused CTRL bits read back as 0.
- Reads: rdata_o is registered, so it is valid exactly one cycle after req_i&!we_i. Unmapped addresses return 0. rdata_o holds its value until the next read.
- FSM:
  - GUARD: an_o=0xFF, dp_o=1. Stay for GUARD cycles, then go to ON.
  - ON: for CLK_DIV-GUARD cycles, an_o[idx]=0 if the digit is visible, otherwise an_o=0xFF. dp_o=~CTRL[8+idx] if visible, otherwise 1. At the end of ON, idx advances (DIGITS-1 wraps to 0) and the FSM returns to GUARD.
- Slot latch: at GUARD entry, the nibble for the new idx and its visibility are latched into slot registers. nibble_o is the latched nibble and is stable for the whole slot (no tearing). A write in the same cycle as GUARD entry is not seen until the next slot.
- Visibility = CTRL.enable & MASK[idx] & !suppressed(idx).
  - suppressed(idx) = lzs & (idx != 0) & (all of DATA[31:4*idx] are 0).
  - Digit 0 is never suppressed.
  - Visibility uses DATA as latched at slot entry.
- Clearing CTRL.enable: an_o goes to 0xFF from the next slot, and immediately, within one cycle, during the ON state. Set an_o to 0xFF in ON whenever the live CTRL.enable is 0. The scan counter keeps running while disabled.
- Outputs: an_o and dp_o are registered, giving one cycle of latency from state and counter to the pins. Outputs are glitch-free.
- Reset mid-scan returns all state to the reset values asynchronously. Scanning restarts at digit 0 in GUARD.

Decomposition:
- Shared package: register offsets ADDR_DATA/ADDR_MASK/ADDR_CTRL, CTRL bit positions, scan state encoding (GUARD, ON), and reset constants for MASK and CTRL.
- One natural sub-module, scan_timer: slot counter, GUARD/ON FSM and digit index. It outputs idx, slot_start and in_on.
- Register file, leading-zero logic and output registers stay in hex_scan_ctrl.

Test Plan:
- Reset then release -> an_o=0xFF and nibble_o=0 for the first GUARD cycles; digit 0 is lit (an_o=0xFE) at cycle GUARD+1.
- Write DATA=0x12345678 -> successive slots show nibble_o 8,7,6,5,4,3,2,1 with an_o FE,FD,FB,F7,EF,DF,BF,7F. Each anode is low for CLK_DIV-GUARD cycles and the index wraps after digit 7.
- MASK=0x0F, DATA=0xFFFFFFFF -> digits 4-7 keep an_o=0xFF for their whole slot while nibble_o still cycles; digits 0-3 light normally.
- CTRL=0x3, DATA=0x000000A0 -> only digits 0 (nibble 0) and 1 (nibble A) light. With DATA=0, only digit 0 lights.
- DATA write mid-slot on digit 2 -> nibble_o stays unchanged until the slot ends and the new value appears from digit 3 onward. Read DATA -> rdata_o equals the written value one cycle after req_i.
- rst_i pulsed during the ON state of digit 5 -> an_o=0xFF and idx=0 without waiting for a clock edge. After release, DATA reads back 0.

Source files
------------

// File: rtl/hex_scan_ctrl_pkg.sv
// Shared definitions for the 8-digit multiplexed 7-segment scan controller:
// register map, CTRL field positions, scan state encoding and reset values.
package hex_scan_ctrl_pkg;

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_MASK = 4'h4;
  localparam logic [3:0] ADDR_CTRL = 4'h8;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_LZS_BIT = 1;
  localparam int unsigned CTRL_DP_LSB  = 8;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  localparam logic [7:0]  MASK_RST = 8'hFF;
  localparam logic [31:0] CTRL_RST = 32'h0000_0001;

endpackage

// File: rtl/hex_scan_ctrl_scan_timer.sv
// Slot timing for the display scan: GUARD (blanked) then ON per digit slot,
// advancing the digit index at the end of each ON period.
module scan_timer
  import hex_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned CLK_DIV = 1000,
  parameter int unsigned GUARD   = 16,
  localparam int unsigned IDX_W  = $clog2(DIGITS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [IDX_W-1:0] idx,
  output logic             slot_start,
  output logic             in_on
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(CLK_DIV - GUARD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx_q, idx_nx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_GUARD;
      cnt   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx_q <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx_q;
    unique case (state)
      ST_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nx = ST_ON;
          cnt_nx   = '0;
        end
      end
      ST_ON: begin
        if (cnt == ON_LAST) begin
          state_nx = ST_GUARD;
          cnt_nx   = '0;
          idx_nx   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
    endcase
  end

  // First GUARD cycle of every slot, with idx already pointing at the new digit.
  assign slot_start = (state == ST_GUARD) && (cnt == '0);
  assign in_on      = (state == ST_ON);
  assign idx        = idx_q;

endmodule

// File: rtl/hex_scan_ctrl.sv
// Bus-mapped 8-digit common-anode display scanner with digit mask,
// leading-zero suppression, per-digit decimal points and guard blanking.
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned CLK_DIV = 1000,
  parameter int unsigned GUARD   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  nibble_o,
  output logic [7:0]  an_o,
  output logic        dp_o
);

  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic [31:0]      data_q;
  logic [7:0]       mask_q;
  logic             en_q, lzs_q;
  logic [7:0]       dp_mask_q;
  logic [IDX_W-1:0] idx;
  logic             slot_start, in_on;
  logic             upper_zero, suppressed, vis_now;
  logic [3:0]       nibble_q;
  logic             vis_q;
  logic [7:0]       an_nx;
  logic             dp_nx;

  scan_timer #(
    .DIGITS  (DIGITS),
    .CLK_DIV (CLK_DIV),
    .GUARD   (GUARD)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx        (idx),
    .slot_start (slot_start),
    .in_on      (in_on)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      mask_q    <= MASK_RST;
      en_q      <= CTRL_RST[CTRL_EN_BIT];
      lzs_q     <= CTRL_RST[CTRL_LZS_BIT];
      dp_mask_q <= CTRL_RST[CTRL_DP_LSB +: 8];
      rdata_o   <= '0;
    end else if (req_i) begin
      if (we_i) begin
        case (addr_i)
          ADDR_DATA: data_q <= wdata_i;
          ADDR_MASK: mask_q <= wdata_i[7:0];
          ADDR_CTRL: begin
            en_q      <= wdata_i[CTRL_EN_BIT];
            lzs_q     <= wdata_i[CTRL_LZS_BIT];
            dp_mask_q <= wdata_i[CTRL_DP_LSB +: 8];
          end
          default: ;
        endcase
      end else begin
        case (addr_i)
          ADDR_DATA: rdata_o <= data_q;
          ADDR_MASK: rdata_o <= {24'h0, mask_q};
          ADDR_CTRL: rdata_o <= {16'h0, dp_mask_q, 6'h0, lzs_q, en_q};
          default:   rdata_o <= '0;
        endcase
      end
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are 0.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (j >= 32'(idx) && data_q[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
  end

  assign suppressed = lzs_q && (idx != '0) && upper_zero;
  assign vis_now    = en_q && mask_q[idx] && !suppressed;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nibble_q <= '0;
      vis_q    <= 1'b0;
    end else if (slot_start) begin
      nibble_q <= data_q[{idx, 2'b00} +: 4];
      vis_q    <= vis_now;
    end
  end

  // Live enable also gates ON so clearing it blanks the current slot at once.
  always_comb begin
    an_nx = '1;
    dp_nx = 1'b1;
    if (in_on && vis_q && en_q) begin
      an_nx[idx] = 1'b0;
      dp_nx      = ~dp_mask_q[idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      an_o <= '1;
      dp_o <= 1'b1;
    end else begin
      an_o <= an_nx;
      dp_o <= dp_nx;
    end
  end

  assign nibble_o = nibble_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: table-driven scan vectors with a
// slot/readback scoreboard, plus hand-written reset, mid-slot and enable cases.
module tb_hex_scan_ctrl;
  import hex_scan_ctrl_pkg::*;

  localparam int unsigned CLK_DIV = 20;
  localparam int unsigned GUARD   = 4;
  localparam int unsigned SCAN    = CLK_DIV * 8;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  nibble;
  logic [7:0]  an;
  logic        dp;

  hex_scan_ctrl #(
    .DIGITS  (8),
    .CLK_DIV (CLK_DIV),
    .GUARD   (GUARD)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .nibble_o (nibble),
    .an_o     (an),
    .dp_o     (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [31:0] ctrl;
    logic [31:0] ctrl_rd;
    logic [63:0] an;
    logic [7:0]  dp;
  } vec_t;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] an;
    logic       dp;
  } slot_exp_t;

  slot_exp_t   sq[$];
  logic [31:0] rq[$];
  vec_t        vecs[6];
  int unsigned p;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    rq.push_back(exp);
    tick();
    req = 1'b0;
    check("rdata", rdata, rq.pop_front());
  endtask

  task automatic push_slot(input logic [3:0] n, input logic [7:0] a, input logic d);
    slot_exp_t e;
    e.nib = n; e.an = a; e.dp = d;
    sq.push_back(e);
  endtask

  // Advance until the next edge begins the slot of digit 0.
  task automatic align();
    while (p % SCAN != 0) tick();
  endtask

  // Expects the next edge to be the first cycle of a slot.
  task automatic scan_check(input int unsigned nslots);
    for (int unsigned s = 0; s < nslots; s++) begin
      slot_exp_t e;
      int unsigned g_ok, on_ok, nib_ok;
      if (sq.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard: no expected slot queued at cycle %0d", p);
        return;
      end
      e = sq.pop_front();
      g_ok = 0; on_ok = 0; nib_ok = 0;
      for (int unsigned o = 0; o < CLK_DIV; o++) begin
        tick();
        if (o < GUARD) begin
          if (an == 8'hFF && dp == 1'b1) g_ok++;
        end else if (an == e.an) on_ok++;
        if (nibble == e.nib) nib_ok++;
        if (o == CLK_DIV / 2) check("slot_dp", 32'(dp), 32'(e.dp));
      end
      check("slot_guard_cycles", g_ok, GUARD);
      check("slot_on_cycles", on_ok, CLK_DIV - GUARD);
      check("slot_nibble_cycles", nib_ok, CLK_DIV);
    end
  endtask

  initial begin
    vecs[0] = '{32'h1234_5678, 8'hFF, 32'h0000_0001, 32'h0000_0001,
                64'h7FBFDFEF_F7FBFDFE, 8'hFF};
    vecs[1] = '{32'hFFFF_FFFF, 8'h0F, 32'hFFFF_00F1, 32'h0000_0001,
                64'hFFFFFFFF_F7FBFDFE, 8'hFF};
    vecs[2] = '{32'h0000_00A0, 8'hFF, 32'h0000_0003, 32'h0000_0003,
                64'hFFFFFFFF_FFFFFDFE, 8'hFF};
    vecs[3] = '{32'h0000_0000, 8'hFF, 32'h0000_0003, 32'h0000_0003,
                64'hFFFFFFFF_FFFFFFFE, 8'hFF};
    vecs[4] = '{32'h0050_0300, 8'hFF, 32'h0000_0503, 32'h0000_0503,
                64'hFFFFDFEF_F7FBFDFE, 8'hFA};
    vecs[5] = '{32'h9ABC_DEF0, 8'hFF, 32'h0000_0000, 32'h0000_0000,
                64'hFFFFFFFF_FFFFFFFF, 8'hFF};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; p = 0;
    #12;
    check("reset_an", 32'(an), 32'hFF);
    check("reset_nibble", 32'(nibble), 32'h0);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0; p = 0;

    for (int unsigned i = 0; i < GUARD; i++) begin
      tick();
      check("first_guard_an", 32'(an), 32'hFF);
      check("first_guard_nibble", 32'(nibble), 32'h0);
    end
    tick();
    check("first_lit_an", 32'(an), 32'hFE);

    rd(ADDR_DATA, 32'h0);
    rd(ADDR_MASK, 32'hFF);
    rd(ADDR_CTRL, 32'h1);

    foreach (vecs[v]) begin
      wr(ADDR_DATA, vecs[v].data);
      wr(ADDR_MASK, 32'(vecs[v].mask));
      wr(ADDR_CTRL, vecs[v].ctrl);
      rd(ADDR_MASK, 32'(vecs[v].mask));
      rd(ADDR_CTRL, vecs[v].ctrl_rd);
      for (int unsigned d = 0; d < 8; d++)
        push_slot(vecs[v].data[4*d +: 4], vecs[v].an[8*d +: 8], vecs[v].dp[d]);
      align();
      scan_check(8);
    end

    // Mid-slot DATA write on digit 2: the current slot keeps the old nibble.
    wr(ADDR_DATA, 32'h1234_5678);
    wr(ADDR_MASK, 32'hFF);
    wr(ADDR_CTRL, 32'h1);
    align();
    push_slot(4'h8, 8'hFE, 1'b1);
    push_slot(4'h7, 8'hFD, 1'b1);
    scan_check(2);
    begin
      int unsigned keep;
      keep = 0;
      for (int unsigned o = 0; o < 9; o++) begin
        tick();
        if (nibble == 4'h6) keep++;
      end
      wr(ADDR_DATA, 32'h9ABC_DEF0);
      if (nibble == 4'h6) keep++;
      for (int unsigned o = 10; o < CLK_DIV; o++) begin
        tick();
        if (nibble == 4'h6) keep++;
      end
      check("midslot_nibble_hold", keep, CLK_DIV);
    end
    push_slot(4'hD, 8'hF7, 1'b1);
    push_slot(4'hC, 8'hEF, 1'b1);
    scan_check(2);
    rd(ADDR_DATA, 32'h9ABC_DEF0);
    repeat (3) tick();
    check("rdata_hold", rdata, 32'h9ABC_DEF0);

    wr(4'hC, 32'hDEAD_BEEF);
    rd(4'hC, 32'h0);
    rd(ADDR_DATA, 32'h9ABC_DEF0);

    // Clearing enable blanks the lit digit within one cycle; scan keeps going.
    align();
    repeat (7) tick();
    check("en_before_clear_an", 32'(an), 32'hFE);
    wr(ADDR_CTRL, 32'h0);
    tick();
    check("en_clear_an", 32'(an), 32'hFF);
    repeat (12) tick();
    check("disabled_scan_nibble", 32'(nibble), 32'hF);
    check("disabled_scan_an", 32'(an), 32'hFF);

    // Asynchronous reset in the ON phase of digit 5.
    wr(ADDR_CTRL, 32'h1);
    align();
    repeat (5 * CLK_DIV + 10) tick();
    check("digit5_on_an", 32'(an), 32'hDF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_an", 32'(an), 32'hFF);
    check("async_reset_nibble", 32'(nibble), 32'h0);
    check("async_reset_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0; p = 0;
    rd(ADDR_DATA, 32'h0);
    while (p < GUARD + 1) tick();
    check("restart_digit0_an", 32'(an), 32'hFE);

    check("scoreboard_empty", sq.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
